// File: rtl/res_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its optional
// 7-segment display decoder.
package res_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int DIGITS = 5;
    localparam int BCD_W  = 20;

    // Active-low gfedcba segment codes
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Pre-shift correction: every digit >= 5 gets +3 so the next shift carries correctly.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] r;
        r = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// One BCD digit to an active-low gfedcba 7-segment code; values 10..15 show blank.
module seg7_dec
    import res_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/res_bcd.sv
// Fixed-latency shift-and-add-3 binary-to-BCD converter (W bits in, five digits out).
// Define RES_BCD_SEG7_EN to add the 35-bit active-low 7-segment output seg.
module res_bcd
    import res_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
`ifdef RES_BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0] seg
`endif
);

    localparam int CNT_W = $clog2(W + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       sr_q, sr_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W+W-1:0] shifted;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        shifted = {dd_adjust(acc_q), sr_q} << 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shifted[BCD_W+W-1:W];
                sr_d  = shifted[W-1:0];
                cnt_d = cnt_q - 1'b1;
                // Last shift: publish the freshly shifted accumulator, not the stale one
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted[BCD_W+W-1:W];
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

`ifdef RES_BCD_SEG7_EN
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_dec u_seg7_dec (
            .digit(bcd_q[4*g +: 4]),
            .seg  (seg[7*g +: 7])
        );
    end
`endif

endmodule

// File: tb/tb_res_bcd.sv
// Directed-vector bench for res_bcd: latency, busy window, start filtering,
// async reset mid-conversion, back-to-back starts and optional seg output.
module tb_res_bcd;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  bin;
    logic          busy;
    logic          done;
    logic [19:0]   bcd;
`ifdef RES_BCD_SEG7_EN
    logic [34:0]   seg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    res_bcd #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .bcd  (bcd)
`ifdef RES_BCD_SEG7_EN
        ,
        .seg  (seg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one conversion; optionally pulse a second start at sample inj_k while busy.
    task automatic run_conv(input string tag, input logic [W-1:0] b, input logic [19:0] exp,
                            input int inj_k, input logic [W-1:0] inj_b);
        int          done_k;
        int          done_n;
        int          busy_n;
        logic        held_ok;
        logic [19:0] prev;
        logic [19:0] bcd_at_done;
        done_k      = -1;
        done_n      = 0;
        busy_n      = 0;
        held_ok     = 1'b1;
        bcd_at_done = '0;
        @(negedge clk);
        prev  = bcd;
        bin   = b;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
                bcd_at_done = bcd;
            end else if (done_n == 0 && bcd !== prev) begin
                held_ok = 1'b0;
            end
            start = (k == inj_k);
            if (k == inj_k) bin = inj_b;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, done_k, W);
        check_eq({tag, "_done_cnt"}, done_n, 1);
        check_eq({tag, "_busy_cnt"}, busy_n, W + 1);
        check_eq({tag, "_bcd_done"}, {12'h0, bcd_at_done}, {12'h0, exp});
        check_eq({tag, "_bcd_hold"}, {12'h0, bcd}, {12'h0, exp});
        check_eq({tag, "_bcd_stable"}, {31'h0, held_ok}, 32'h1);
    endtask

    initial begin
        int d_idx[$];
        logic bcd7_ok;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_done", {31'h0, done}, 32'h0);
        check_eq("rst_bcd", {12'h0, bcd}, 32'h0);
        rst = 1'b0;

        run_conv("zero",  16'd0,     20'h00000, -1, '0);
        run_conv("max",   16'd65535, 20'h65535, -1, '0);
        run_conv("n1234", 16'd1234,  20'h01234, -1, '0);
        run_conv("n9999", 16'd9999,  20'h09999, -1, '0);
        run_conv("n10000",16'd10000, 20'h10000, -1, '0);
        run_conv("busy_start", 16'd100, 20'h00100, 3, 16'd999);

        // Async reset at cycle 5 of a conversion
        @(negedge clk);
        bin   = 16'd500;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'h0, busy}, 32'h0);
        check_eq("arst_done", {31'h0, done}, 32'h0);
        check_eq("arst_bcd", {12'h0, bcd}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_rst_idle", {31'h0, busy}, 32'h0);
        run_conv("after_rst", 16'd42, 20'h00042, -1, '0);

        // Start held high: one conversion every W+2 cycles
        @(negedge clk);
        bin   = 16'd7;
        start = 1'b1;
        bcd7_ok = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3 * (W + 2); k++) begin
            @(negedge clk);
            if (done) begin
                d_idx.push_back(k);
                if (bcd !== 20'h00007) bcd7_ok = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("cont_done_cnt", d_idx.size(), 3);
        if (d_idx.size() == 3) begin
            check_eq("cont_first", d_idx[0], W);
            check_eq("cont_gap1", d_idx[1] - d_idx[0], W + 2);
            check_eq("cont_gap2", d_idx[2] - d_idx[1], W + 2);
        end
        check_eq("cont_bcd", {31'h0, bcd7_ok}, 32'h1);
        repeat (W + 4) @(negedge clk);
        check_eq("cont_idle", {31'h0, busy}, 32'h0);

`ifdef RES_BCD_SEG7_EN
        run_conv("seg8", 16'd8, 20'h00008, -1, '0);
        check_eq("seg_d0", {25'h0, seg[6:0]}, 32'h00);
        check_eq("seg_d1", {25'h0, seg[13:7]}, 32'h40);
        check_eq("seg_d4", {25'h0, seg[34:28]}, 32'h40);
        run_conv("seg1234", 16'd1234, 20'h01234, -1, '0);
        check_eq("seg_1234_lo", {25'h0, seg[6:0]}, 32'h19);
        check_eq("seg_1234_d3", {25'h0, seg[27:21]}, 32'h79);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/res_bcd.md
RES_BCD -- requirements
Module: res_bcd

Interface
- REQ-001: Parameter W, default 16, sets the binary input width; legal values are 8..16.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: start  input  1  request pulse; sampled on rising clk.
- REQ-005: bin  input  W  unsigned result from the arithmetic stage; sampled only when start is accepted.
- REQ-006: busy  output  1  high while a conversion is in progress.
- REQ-007: done  output  1  one-cycle pulse when bcd is updated.
- REQ-008: bcd  output  20  five packed BCD digits; digit 0 is in [3:0]; unused upper digits read 0.

Function
- REQ-009: The FSM SHALL have exactly three states: IDLE, SHIFT and FINISH.
- REQ-010: In IDLE, start=1 at a clock edge (edge 0) SHALL:
  - load bin into the shift register;
  - clear the 20-bit digit accumulator;
  - load the bit counter with W;
  - enter SHIFT.
- REQ-011: Each SHIFT edge SHALL do the following, in this order:
  - add 3 to every accumulator digit that is >= 5;
  - shift {accumulator, shift register} left by 1;
  - decrement the counter.
- REQ-012: On the edge where the counter reaches 0, the FSM SHALL copy the accumulator into the bcd register, assert done and go to FINISH.
- REQ-013: FINISH SHALL last exactly one cycle and then return to IDLE.
- REQ-014: Latency SHALL be fixed: done is high in the cycle after edge W, independent of the data value.
- REQ-015: busy SHALL be high from the cycle after edge 0 through the cycle in which done is high.
- REQ-016: start while busy SHALL be ignored and SHALL have no effect on the conversion in flight.
- REQ-017: start sampled during the FINISH cycle SHALL be ignored.
- REQ-018: start asserted in the first IDLE cycle after FINISH SHALL be accepted.
- REQ-019: bcd SHALL hold its last value between completions; it changes only on the done edge.
- REQ-020: A start that arrives while bin is X SHALL still complete in W cycles (no data-dependent early exit).

Reset
- REQ-021: rst=1 SHALL asynchronously force the following, including mid-conversion:
  - state to IDLE;
  - busy=0, done=0, bcd=0;
  - counter, shift register and accumulator to 0.
- REQ-022: The first start accepted after rst is deasserted SHALL behave exactly as from power-up.

Configuration
- REQ-023: With macro RES_BCD_SEG7_EN defined, the module SHALL add output seg  output  35, holding five active-low 7-segment codes (gfedcba); digit n occupies [7n+6:7n].
  - seg is driven combinationally from the registered bcd.
  - Digit values 10..15 SHALL display blank (all 1).
- REQ-024: Without RES_BCD_SEG7_EN, the seg port and the decoder logic SHALL NOT exist.

Structure
- REQ-025: The shared package res_pkg SHALL hold:
  - the state enum typedef (IDLE, SHIFT, FINISH);
  - constant DIGITS=5 and constant BCD_W=20;
  - the 7-segment code constants for 0..9 and blank.
- REQ-026: The 7-segment lookup SHALL be one sub-module, seg7_dec (4-bit digit in, 7-bit active-low code out), instantiated five times under RES_BCD_SEG7_EN.

Verification
- REQ-027: bin=0, start pulse -> done exactly W cycles after the start edge; bcd=20'h00000.
- REQ-028: bin=16'd65535 -> bcd=20'h65535 at done; bin=16'd1234 -> bcd=20'h01234; busy high for W+1 cycles.
- REQ-029: start with bin=16'd100, then start with bin=16'd999 while busy -> done pulses once; bcd=20'h00100.
- REQ-030: rst pulsed at cycle 5 of a conversion -> busy=0, done=0, bcd=0 immediately; a new start with bin=16'd42 then gives bcd=20'h00042.
- REQ-031: start held high continuously with bin=16'd7 -> a conversion every W+2 cycles; each ends with a one-cycle done pulse and bcd=20'h00007.
- REQ-032: RES_BCD_SEG7_EN defined, bin=16'd8 -> seg[6:0]=7'b0000000 and seg[13:7]=7'b1000000 ("0").
